// File: rtl/sync_multi_table_fifo.sv
// Pops a message, then streams its cell groups in lockstep across the masked channels.
// Optional debug counters on dbg_sig when SYNC_MTF_DBG_EN is defined.
module sync_multi_table_fifo #(
  parameter int CELL_CHN_NUM = 4,
  parameter int INFO_WID     = 16,
  parameter int CDWID        = 128,
  parameter int MAX_CELLSZ   = 4,
  parameter int GAP_NUM      = 2,
  localparam int CNT_WID     = (MAX_CELLSZ > 2) ? $clog2(MAX_CELLSZ) : 1,
  localparam int CDWID_SUM   = CELL_CHN_NUM * CDWID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_msg_nempty,
  output logic                    in_msg_rd,
  input  logic [INFO_WID-1:0]     in_msg_rdata,
  input  logic [CELL_CHN_NUM-1:0] in_cpkt_nempty,
  output logic [CELL_CHN_NUM-1:0] in_cpkt_rd,
  output logic [CELL_CHN_NUM-1:0] in_cpkt_reoc,
  input  logic [CDWID_SUM-1:0]    in_cpkt_rdata,
  output logic                    out_msg_vld,
  input  logic                    out_msg_rdy,
  output logic [INFO_WID-1:0]     out_msg_dat,
  output logic [CELL_CHN_NUM-1:0] out_cpkt_vld,
  output logic [CELL_CHN_NUM-1:0] out_cpkt_last,
  input  logic [CELL_CHN_NUM-1:0] out_cpkt_rdy,
  output logic [CDWID_SUM-1:0]    out_cpkt_dat,
  output logic [31:0]             dbg_sig
);

  // state | meaning
  // IDLE  | waiting for the inter-message gap and a message to pop
  // CELL  | streaming cell beats of the current message

  typedef enum logic {S_IDLE, S_CELL} state_t;

  localparam logic [CNT_WID:0] MAX_CELLS = (CNT_WID+1)'(MAX_CELLSZ);
  localparam logic [CNT_WID:0] ONE_BEAT  = (CNT_WID+1)'(1);
  localparam logic [15:0]      GAP_THR   = 16'(GAP_NUM);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CELL_CHN_NUM-1:0] r_mask;
  logic [CNT_WID:0]        r_beat_rem;
  logic [15:0]             r_gap_cnt;
  logic                    r_msg_vld;
  logic [INFO_WID-1:0]     r_msg_dat;
  logic [CELL_CHN_NUM-1:0] r_cpkt_vld;
  logic [CELL_CHN_NUM-1:0] r_cpkt_last;
  logic [CDWID_SUM-1:0]    r_cpkt_dat;

  logic [CELL_CHN_NUM-1:0] w_msg_mask;
  logic [CNT_WID-1:0]      w_msg_n;
  logic [CNT_WID:0]        w_n_p1;
  logic [CNT_WID:0]        w_cell_num;
  logic                    w_msg_rd;
  logic [CELL_CHN_NUM-1:0] w_chn_ok;
  logic                    w_fire;
  logic                    w_last_beat;

  assign w_msg_mask  = in_msg_rdata[CELL_CHN_NUM-1:0];
  assign w_msg_n     = in_msg_rdata[CELL_CHN_NUM +: CNT_WID];
  assign w_n_p1      = {1'b0, w_msg_n} + {{CNT_WID{1'b0}}, 1'b1};
  assign w_cell_num  = (w_n_p1 > MAX_CELLS) ? MAX_CELLS : w_n_p1;

  // Pops are gated by rst so nothing is consumed while the block is held in reset.
  assign w_msg_rd    = !rst && (r_state == S_IDLE) && in_msg_nempty &&
                       (r_gap_cnt >= GAP_THR) && (!r_msg_vld || out_msg_rdy);
  assign w_chn_ok    = ~r_mask | (in_cpkt_nempty & (~r_cpkt_vld | out_cpkt_rdy));
  assign w_fire      = !rst && (r_state == S_CELL) && (&w_chn_ok);
  assign w_last_beat = (r_beat_rem == ONE_BEAT);

  assign in_msg_rd     = w_msg_rd;
  assign in_cpkt_rd    = w_fire ? r_mask : '0;
  assign in_cpkt_reoc  = (w_fire && w_last_beat) ? r_mask : '0;
  assign out_msg_vld   = r_msg_vld;
  assign out_msg_dat   = r_msg_dat;
  assign out_cpkt_vld  = r_cpkt_vld;
  assign out_cpkt_last = r_cpkt_last;
  assign out_cpkt_dat  = r_cpkt_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_msg_rd && (|w_msg_mask)) w_state_nxt = S_CELL;
      S_CELL: if (w_fire && w_last_beat)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt  <= GAP_THR;
      r_mask     <= '0;
      r_beat_rem <= '0;
      r_msg_vld  <= 1'b0;
      r_msg_dat  <= '0;
    end else begin
      if ((w_fire && w_last_beat) || (w_msg_rd && !(|w_msg_mask)))
        r_gap_cnt <= '0;
      else if ((r_state == S_IDLE) && (r_gap_cnt != 16'hFFFF))
        r_gap_cnt <= r_gap_cnt + 16'd1;

      if (w_msg_rd) begin
        r_msg_vld  <= 1'b1;
        r_msg_dat  <= in_msg_rdata;
        r_mask     <= w_msg_mask;
        r_beat_rem <= w_cell_num;
      end else begin
        if (out_msg_rdy) r_msg_vld <= 1'b0;
        if (w_fire)      r_beat_rem <= r_beat_rem - ONE_BEAT;
      end
    end
  end

  // Each channel's output register drains on its own ready; only masked channels reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpkt_vld  <= '0;
      r_cpkt_last <= '0;
      r_cpkt_dat  <= '0;
    end else begin
      for (int i = 0; i < CELL_CHN_NUM; i++) begin
        if (w_fire && r_mask[i]) begin
          r_cpkt_vld[i]               <= 1'b1;
          r_cpkt_last[i]              <= w_last_beat;
          r_cpkt_dat[i*CDWID +: CDWID] <= in_cpkt_rdata[i*CDWID +: CDWID];
        end else if (out_cpkt_rdy[i]) begin
          r_cpkt_vld[i]  <= 1'b0;
          r_cpkt_last[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SYNC_MTF_DBG_EN
  logic [15:0] r_dbg_msg_cnt;
  logic [15:0] r_dbg_beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_msg_cnt  <= '0;
      r_dbg_beat_cnt <= '0;
    end else begin
      if (w_msg_rd) r_dbg_msg_cnt  <= r_dbg_msg_cnt + 16'd1;
      if (w_fire)   r_dbg_beat_cnt <= r_dbg_beat_cnt + 16'd1;
    end
  end

  assign dbg_sig = {r_dbg_msg_cnt, r_dbg_beat_cnt};
`else
  assign dbg_sig = 32'h0;
`endif

endmodule

// File: tb/tb_sync_multi_table_fifo.sv
// Scoreboard bench for sync_multi_table_fifo: models the source FIFOs and checks
// message/cell outputs plus pop timing (gap, stall, reset abandonment).
module tb_sync_multi_table_fifo;

  localparam int CH   = 4;
  localparam int IW   = 16;
  localparam int CDW  = 128;
  localparam int MAXC = 4;
  localparam int GAP  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_msg_nempty;
  logic              in_msg_rd;
  logic [IW-1:0]     in_msg_rdata;
  logic [CH-1:0]     in_cpkt_nempty;
  logic [CH-1:0]     in_cpkt_rd;
  logic [CH-1:0]     in_cpkt_reoc;
  logic [CH*CDW-1:0] in_cpkt_rdata;
  logic              out_msg_vld;
  logic              out_msg_rdy;
  logic [IW-1:0]     out_msg_dat;
  logic [CH-1:0]     out_cpkt_vld;
  logic [CH-1:0]     out_cpkt_last;
  logic [CH-1:0]     out_cpkt_rdy;
  logic [CH*CDW-1:0] out_cpkt_dat;
  logic [31:0]       dbg_sig;

  sync_multi_table_fifo #(
    .CELL_CHN_NUM(CH), .INFO_WID(IW), .CDWID(CDW), .MAX_CELLSZ(MAXC), .GAP_NUM(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_msg_nempty(in_msg_nempty), .in_msg_rd(in_msg_rd), .in_msg_rdata(in_msg_rdata),
    .in_cpkt_nempty(in_cpkt_nempty), .in_cpkt_rd(in_cpkt_rd), .in_cpkt_reoc(in_cpkt_reoc),
    .in_cpkt_rdata(in_cpkt_rdata),
    .out_msg_vld(out_msg_vld), .out_msg_rdy(out_msg_rdy), .out_msg_dat(out_msg_dat),
    .out_cpkt_vld(out_cpkt_vld), .out_cpkt_last(out_cpkt_last), .out_cpkt_rdy(out_cpkt_rdy),
    .out_cpkt_dat(out_cpkt_dat), .dbg_sig(dbg_sig)
  );

  always #5 clk = ~clk;

  logic [IW-1:0]  msg_q[$];
  logic [IW-1:0]  exp_msg_q[$];
  logic [CDW-1:0] cq[CH][$];
  logic [CDW:0]   exp_cq[CH][$];
  int msg_rd_cycs[$];
  int fire_cycs[$];
  int reoc_cycs[$];
  int pop_cnt[CH];
  int n_chk = 0, n_fail = 0, cyc = 0, n_fire = 0, n_msg_rd = 0;
  logic [CH-1:0] hold = '0;
  logic [CH-1:0] last_reoc = '0;
  bit rnd_en = 1'b0;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_msg(input logic [IW-1:0] m);
    int cells;
    logic [CDW-1:0] d;
    msg_q.push_back(m);
    exp_msg_q.push_back(m);
    cells = int'(m[5:4]) + 1;
    if (cells > MAXC) cells = MAXC;
    for (int c = 0; c < CH; c++) begin
      if (m[c]) begin
        for (int b = 0; b < cells; b++) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          cq[c].push_back(d);
          exp_cq[c].push_back({(b == cells - 1), d});
        end
      end
    end
  endtask

  function automatic int pending();
    int s;
    s = msg_q.size() + exp_msg_q.size();
    for (int c = 0; c < CH; c++) s += exp_cq[c].size();
    return s;
  endfunction

  task automatic flush_all();
    msg_q.delete();
    exp_msg_q.delete();
    for (int c = 0; c < CH; c++) begin
      cq[c].delete();
      exp_cq[c].delete();
    end
  endtask

  task automatic refresh();
    in_msg_nempty = (msg_q.size() != 0);
    in_msg_rdata  = in_msg_nempty ? msg_q[0] : '0;
    for (int c = 0; c < CH; c++) begin
      in_cpkt_nempty[c] = (cq[c].size() != 0) && !hold[c];
      in_cpkt_rdata[c*CDW +: CDW] = (cq[c].size() != 0) ? cq[c][0] : '0;
    end
    if (rnd_en) begin
      out_msg_rdy  = ($urandom_range(0, 3) != 0);
      out_cpkt_rdy = CH'($urandom);
    end
  endtask

  // One clock: drive at the falling edge, sample just before the rising edge,
  // then update the source FIFO model and the scoreboard.
  task automatic tick();
    logic p_msg_rd, p_msg_ne, p_rst, p_msg_hs;
    logic [IW-1:0] p_msg_dat;
    logic [CH-1:0] p_cpkt_rd, p_cpkt_ne, p_reoc, p_c_hs, p_c_last;
    logic [CH*CDW-1:0] p_c_dat;
    logic [CDW:0] e;
    refresh();
    #4;
    p_msg_rd  = in_msg_rd;      p_msg_ne  = in_msg_nempty;
    p_cpkt_rd = in_cpkt_rd;     p_cpkt_ne = in_cpkt_nempty;
    p_reoc    = in_cpkt_reoc;   p_rst     = rst;
    p_msg_hs  = out_msg_vld && out_msg_rdy;  p_msg_dat = out_msg_dat;
    p_c_hs    = out_cpkt_vld & out_cpkt_rdy; p_c_last  = out_cpkt_last;
    p_c_dat   = out_cpkt_dat;
    @(posedge clk);
    cyc++;
    #1;
    if (p_rst) begin
      chk("rst_msg_rd", p_msg_rd, 0);
      chk("rst_cpkt_rd", p_cpkt_rd, 0);
    end
    if (p_msg_rd) begin
      chk("msg_rd_nempty", p_msg_ne, 1);
      if (msg_q.size() != 0) void'(msg_q.pop_front());
      msg_rd_cycs.push_back(cyc);
      n_msg_rd++;
    end
    if (|p_cpkt_rd) begin
      chk("rd_exclusive", p_msg_rd, 0);
      chk("cpkt_rd_nempty", p_cpkt_rd & ~p_cpkt_ne, 0);
      chk("reoc_subset", p_reoc & ~p_cpkt_rd, 0);
      n_fire++;
      fire_cycs.push_back(cyc);
      if (|p_reoc) begin
        reoc_cycs.push_back(cyc);
        last_reoc = p_reoc;
      end
      for (int c = 0; c < CH; c++) begin
        if (p_cpkt_rd[c]) begin
          pop_cnt[c]++;
          if (cq[c].size() != 0) void'(cq[c].pop_front());
        end
      end
    end else begin
      chk("reoc_without_rd", p_reoc, 0);
    end
    if (p_msg_hs) begin
      if (exp_msg_q.size() == 0) chk("msg_unexpected_qsize", exp_msg_q.size(), 1);
      else chk("msg_dat", p_msg_dat, exp_msg_q.pop_front());
    end
    for (int c = 0; c < CH; c++) begin
      if (p_c_hs[c]) begin
        if (exp_cq[c].size() == 0) chk("cell_unexpected_qsize", exp_cq[c].size(), 1);
        else begin
          e = exp_cq[c].pop_front();
          chk($sformatf("cell_ch%0d_last_dat", c), {p_c_last[c], p_c_dat[c*CDW +: CDW]}, e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (pending() != 0 && k < budget) begin
      tick();
      k++;
    end
    repeat (2) tick();
    chk(tag, pending(), 0);
  endtask

  task automatic wait_fires(input string tag, input int target, input int budget);
    int k = 0;
    while (n_fire < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, (n_fire >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, m, k, r, p1, p3;
    logic [CDW-1:0] held;
    rst = 1'b1;
    out_msg_rdy = 1'b1;
    out_cpkt_rdy = '1;
    in_msg_nempty = 1'b0;
    in_msg_rdata = '0;
    in_cpkt_nempty = '0;
    in_cpkt_rdata = '0;
    for (int c = 0; c < CH; c++) pop_cnt[c] = 0;
    @(negedge clk);

    // Reset: outputs quiet, no pop even with a message waiting.
    push_msg(16'h0011);
    tick();
    tick();
    refresh();
    chk("rst_out_msg_vld", out_msg_vld, 0);
    chk("rst_out_cpkt_vld", out_cpkt_vld, 0);
    chk("rst_out_cpkt_last", out_cpkt_last, 0);
    chk("rst_in_msg_rd", in_msg_rd, 0);
    chk("rst_dbg", dbg_sig, 0);
    rst = 1'b0;
    k = cyc;
    tick();
    chk("first_pop_immediate", msg_rd_cycs[0], k + 1);
    drain("drain_first", 50);

    // Mask 0101, 3 cells; ch1/ch3 hold data that must never be read.
    for (int j = 0; j < 3; j++) begin
      cq[1].push_back(CDW'($urandom));
      cq[3].push_back(CDW'($urandom));
    end
    p1 = pop_cnt[1];
    p3 = pop_cnt[3];
    b = n_fire;
    m = n_msg_rd;
    push_msg(16'h0025);
    drain("drain_t1", 50);
    chk("t1_beats", n_fire - b, 3);
    chk("t1_first_beat_lat", fire_cycs[b] - msg_rd_cycs[m], 1);
    chk("t1_consec_12", fire_cycs[b+1] - fire_cycs[b], 1);
    chk("t1_consec_23", fire_cycs[b+2] - fire_cycs[b+1], 1);
    chk("t1_reoc_on_third", reoc_cycs[$], fire_cycs[b+2]);
    chk("t1_reoc_mask", last_reoc, 4'b0101);
    chk("t1_ch1_untouched", pop_cnt[1] - p1, 0);
    chk("t1_ch3_untouched", pop_cnt[3] - p3, 0);
    cq[1].delete();
    cq[3].delete();

    // ch2 back-pressure after the first beat stalls both masked channels.
    b = n_fire;
    push_msg(16'h0025);
    wait_fires("t2_first_beat", b + 1, 50);
    out_cpkt_rdy[2] = 1'b0;
    held = out_cpkt_dat[2*CDW +: CDW];
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t2_stall_vld2", out_cpkt_vld[2], 1);
      chk("t2_stall_dat2", out_cpkt_dat[2*CDW +: CDW], held);
    end
    chk("t2_no_fire_in_stall", n_fire - b, 1);
    out_cpkt_rdy[2] = 1'b1;
    drain("drain_t2", 50);
    chk("t2_resume_gap", fire_cycs[b+1] - fire_cycs[b], 6);
    chk("t2_beats", n_fire - b, 3);

    // Mask 0011 with ch1 empty for 4 cycles.
    hold = 4'b0010;
    b = n_fire;
    m = n_msg_rd;
    push_msg(16'h0013);
    k = 0;
    while (n_msg_rd == m && k < 20) begin
      tick();
      k++;
    end
    chk("t3_msg_popped", n_msg_rd - m, 1);
    repeat (4) tick();
    chk("t3_blocked", n_fire - b, 0);
    hold = '0;
    r = cyc;
    drain("drain_t3", 50);
    chk("t3_beat_on_release", fire_cycs[b], r + 1);
    chk("t3_beats", n_fire - b, 2);

    // Back-to-back single-cell messages honour the gap.
    b = n_fire;
    m = n_msg_rd;
    push_msg(16'h0001);
    push_msg(16'h0001);
    drain("drain_t4", 60);
    chk("t4_gap_after_last", msg_rd_cycs[m+1] - fire_cycs[b], 3);

    // Zero-mask messages: message only, gap still applies.
    b = n_fire;
    m = n_msg_rd;
    push_msg(16'h0010);
    push_msg(16'h0000);
    drain("drain_t4z", 60);
    chk("t4z_no_cells", n_fire - b, 0);
    chk("t4z_msgs", n_msg_rd - m, 2);
    chk("t4z_gap", msg_rd_cycs[m+1] - msg_rd_cycs[m], 3);

    // Cells proceed while the message output is back-pressured.
    out_msg_rdy = 1'b0;
    b = n_fire;
    push_msg(16'h0011);
    wait_fires("t5_cells_wait", b + 2, 30);
    chk("t5_msg_still_pending", out_msg_vld, 1);
    out_msg_rdy = 1'b1;
    drain("drain_t5", 50);

    // Count field above CNT_WID bits is ignored: 4 beats.
    b = n_fire;
    push_msg(16'h0071);
    drain("drain_t6", 60);
    chk("t6_beats", n_fire - b, 4);

    // Reset during beat 2 abandons the group; next message pops at once.
    b = n_fire;
    push_msg(16'h0071);
    wait_fires("t7_two_beats", b + 2, 60);
    flush_all();
    push_msg(16'h0011);
    rst = 1'b1;
    tick();
    refresh();
    chk("t7_rst_msg_vld", out_msg_vld, 0);
    chk("t7_rst_cpkt_vld", out_cpkt_vld, 0);
    chk("t7_rst_cpkt_last", out_cpkt_last, 0);
    chk("t7_rst_cpkt_dat", |out_cpkt_dat, 0);
    chk("t7_rst_in_msg_rd", in_msg_rd, 0);
    chk("t7_rst_in_cpkt_rd", in_cpkt_rd, 0);
    chk("t7_no_fire_in_rst", n_fire - b, 2);
    rst = 1'b0;
    k = cyc;
    m = n_msg_rd;
    tick();
    chk("t7_pop_after_rst", msg_rd_cycs[m], k + 1);
    drain("drain_t7", 50);

    // Debug counters: 3 messages x 2 cells after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) push_msg(16'h0011);
    drain("drain_t8", 100);
`ifdef SYNC_MTF_DBG_EN
    chk("t8_dbg_counts", dbg_sig, 32'h0003_0006);
`else
    chk("t8_dbg_off", dbg_sig, 32'h0);
`endif

    // Random messages with random back-pressure.
    rnd_en = 1'b1;
    for (int j = 0; j < 20; j++) push_msg(IW'($urandom));
    drain("drain_rand", 3000);
    rnd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
